// File: rtl/trivium_stream_decrypt.sv
// Trivium receive-side decryptor: ciphertext byte in, plaintext byte out 9 clocks after accept, LSB pairs with first keystream bit.
// Backpressure: core freezes in HOLD until pt_ready; ct_ready only in IDLE, so one byte in flight at a time.
module trivium_stream_decrypt #(
    parameter logic [79:0] KEY         = 80'h9719CFC92A9FF688F9AA,
    parameter int          INIT_ROUNDS = 1152,
    parameter int          CNT_W       = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] iv_in,
    input  logic        resync,
    input  logic [7:0]  ct_data,
    input  logic        ct_valid,
    output logic        ct_ready,
    output logic [7:0]  pt_data,
    output logic        pt_valid,
    input  logic        pt_ready,
    output logic        busy
);

    typedef enum logic [1:0] {WARMUP, IDLE, RUN, HOLD} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INIT_ROUNDS - 1);

    state_t         state, state_nxt;
    logic [287:0]   s, s_step, s_load;
    logic [CNT_W-1:0] cnt;
    logic [2:0]     bitidx;
    logic [7:0]     ct_shadow, pt_shadow, pt_full;
    logic           t1, t2, t3, z, t1f, t2f, t3f;
    logic           step, accept;

    assign s_load = {KEY, 13'b0, iv_in, 112'b0, 3'b111};

    always_comb begin
        t1     = s[222] ^ s[195];
        t2     = s[126] ^ s[111];
        t3     = s[45]  ^ s[0];
        z      = t1 ^ t2 ^ t3;
        t1f    = t1 ^ (s[197] & s[196]) ^ s[117];
        t2f    = t2 ^ (s[113] & s[112]) ^ s[24];
        t3f    = t3 ^ (s[2] & s[1]) ^ s[219];
        s_step = {t3f, s[287:196], t1f, s[194:112], t2f, s[110:1]};
    end

    always_comb begin
        pt_full         = pt_shadow;
        pt_full[bitidx] = ct_shadow[bitidx] ^ z;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WARMUP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        accept    = 1'b0;
        ct_ready  = (state == IDLE);
        pt_valid  = (state == HOLD);
        busy      = (state == WARMUP) || (state == RUN);
        case (state)
            WARMUP: begin
                step = 1'b1;
                if (cnt == LAST_CNT) state_nxt = IDLE;
            end
            IDLE: begin
                if (ct_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (bitidx == 3'd7) state_nxt = HOLD;
            end
            HOLD: begin
                if (pt_ready) state_nxt = IDLE;
            end
            default: state_nxt = WARMUP;
        endcase
        // resync overrides any handshake or step in the same cycle
        if (resync) begin
            state_nxt = WARMUP;
            step      = 1'b0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= s_load;
            cnt       <= '0;
            bitidx    <= '0;
            ct_shadow <= '0;
            pt_shadow <= '0;
            pt_data   <= '0;
        end else if (resync) begin
            s      <= s_load;
            cnt    <= '0;
            bitidx <= '0;
        end else begin
            if (step) s <= s_step;
            if (state == WARMUP) cnt <= cnt + 1'b1;
            if (accept) begin
                ct_shadow <= ct_data;
                bitidx    <= '0;
            end
            if (state == RUN) begin
                pt_shadow <= pt_full;
                bitidx    <= bitidx + 3'd1;
                if (bitidx == 3'd7) pt_data <= pt_full;
            end
        end
    end

endmodule
